// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared fetch-stage defaults and fetch FSM state encoding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int              C_PC_W     = 16;
  localparam int              C_INSTR_W  = 32;
  localparam int              C_DEPTH    = 4;
  localparam logic [15:0]     C_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_REDIR = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_queue.sv
// ============================================================================
// ifu_queue : synchronous IR FIFO carrying {pc, instruction} with flush
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ifu_queue #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [PC_W-1:0]    i_push_pc,
  input  logic [INSTR_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic               o_valid,
  output logic [PC_W-1:0]    o_head_pc,
  output logic [INSTR_W-1:0] o_head_data,
  output logic [CW-1:0]      o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]    r_mem_pc   [DEPTH];
  logic [INSTR_W-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [CW-1:0]      r_count;
  logic [PC_W-1:0]    r_head_pc;
  logic [INSTR_W-1:0] r_head_data;

  logic               w_pop;
  logic [PW-1:0]      w_rd_nxt;
  logic [CW-1:0]      w_remain;
  logic [CW-1:0]      w_cnt_nxt;

  assign w_pop     = i_pop && (r_count != '0);
  assign w_rd_nxt  = r_rd + PW'(w_pop);
  assign w_remain  = r_count - CW'(w_pop);
  assign w_cnt_nxt = w_remain + CW'(i_push);

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem_pc[r_wr]   <= i_push_pc;
      r_mem_data[r_wr] <= i_push_data;
    end
  end

  // Head is registered; when the queue is about to hold only the incoming
  // word, it is taken straight from the push port since memory is not yet written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_head_pc   <= '0;
      r_head_data <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + PW'(i_push);
      r_rd    <= w_rd_nxt;
      r_count <= w_cnt_nxt;
      if (w_cnt_nxt != '0) begin
        if (w_remain == '0) begin
          r_head_pc   <= i_push_pc;
          r_head_data <= i_push_data;
        end else begin
          r_head_pc   <= r_mem_pc[w_rd_nxt];
          r_head_data <= r_mem_data[w_rd_nxt];
        end
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
    !(i_push && !i_flush && (r_count == CW'(DEPTH))));

  assign o_valid     = (r_count != '0);
  assign o_head_pc   = r_head_pc;
  assign o_head_data = r_head_data;
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC, credit-limited imem requests, redirect/flush, IR queue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = C_PC_W,
  parameter int              INSTR_W  = C_INSTR_W,
  parameter int              DEPTH    = C_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(C_RESET_PC)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [PC_W-1:0]    ir_pc,
  input  logic               ir_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic            r_inflight;
  logic [PC_W-1:0] r_infl_pc;

  logic [CW-1:0]   w_count;
  logic            w_credit;
  logic            w_req;
  logic            w_kill;
  logic            w_push;

  // Credit counts the in-flight slot so a response always finds a free entry.
  assign w_credit = ({1'b0, w_count} + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH);
  assign w_req    = rstn && fetch_en && !redirect && w_credit;
  assign w_kill   = redirect;
  assign w_push   = r_inflight && !w_kill;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= FS_IDLE;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_infl_pc  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_req;
      if (w_req) begin
        r_infl_pc <= r_pc;
      end
      if (redirect) begin
        r_pc <= redirect_pc;
      end else begin
        r_pc <= r_pc + PC_W'(w_req);
      end
    end
  end

  always_comb begin
    w_state_nxt = FS_IDLE;
    if (redirect) begin
      w_state_nxt = FS_REDIR;
    end else begin
      case (r_state)
        FS_REDIR: w_state_nxt = fetch_en ? FS_RUN : FS_IDLE;
        default:  w_state_nxt = w_req ? FS_RUN : FS_IDLE;
      endcase
    end
  end

  ifu_queue #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .CW      (CW)
  ) u_queue (
    .clk         (clk),
    .rstn        (rstn),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_pc   (r_infl_pc),
    .i_push_data (imem_rdata),
    .i_pop       (ir_ready),
    .o_valid     (ir_valid),
    .o_head_pc   (ir_pc),
    .o_head_data (ir_data),
    .o_count     (w_count)
  );

  assign imem_req  = w_req;
  assign imem_addr = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : randomized scoreboard bench for instr_fetch_unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               fetch_en = 1'b0;
  logic               redirect = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_data;
  logic [PC_W-1:0]    ir_pc;
  logic               ir_ready = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  function automatic logic [INSTR_W-1:0] word_of(input logic [PC_W-1:0] a);
    return {~a, a ^ 16'hC3A5};
  endfunction

  // Instruction memory: data for a request appears one cycle later.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? word_of(imem_addr) : 32'hDEAD_BEEF;
  end

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] data;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Reference model: program counter, list of queued PCs, one in-flight slot.
  logic [PC_W-1:0] m_pc = '0;
  logic [PC_W-1:0] m_q[$];
  bit              m_infl = 1'b0;
  logic [PC_W-1:0] m_infl_pc = '0;
  exp_t            sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit fe, input bit rdy, input bit rd, input logic [PC_W-1:0] rpc);
    bit exp_req;
    @(posedge clk);
    #1;
    fetch_en    = fe;
    ir_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    exp_req = fe && !rd && ((m_q.size() + int'(m_infl)) < DEPTH);
    check("imem_req", 64'(imem_req), 64'(exp_req));
    check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("ir_valid", 64'(ir_valid), 64'(m_q.size() != 0));
    if (rd) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = rpc;
    end else begin
      if (m_q.size() != 0 && rdy) begin
        sb.push_back('{pc: m_q[0], data: word_of(m_q[0])});
        void'(m_q.pop_front());
      end
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl    = exp_req;
      m_infl_pc = m_pc;
      if (exp_req) m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn     = 1'b0;
    fetch_en = 1'b0;
    redirect = 1'b0;
    ir_ready = 1'b0;
    #1;
    check("rst_ir_valid", 64'(ir_valid), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd0);
    m_pc   = '0;
    m_infl = 1'b0;
    m_q.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: every accepted head must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rstn && ir_valid && ir_ready && !redirect) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL deliver_unexpected actual_pc=%0h required=none", ir_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ir_pc !== e.pc || ir_data !== e.data) begin
          errors++;
          $display("FAIL deliver actual pc=%0h data=%0h required pc=%0h data=%0h",
                   ir_pc, ir_data, e.pc, e.data);
        end
      end
    end
  end

  initial begin
    rstn     = 1'b0;
    fetch_en = 1'b1;
    #12;
    check("init_ir_valid", 64'(ir_valid), 64'd0);
    check("init_ir_data", 64'(ir_data), 64'd0);
    check("init_ir_pc", 64'(ir_pc), 64'd0);
    check("init_imem_addr", 64'(imem_addr), 64'd0);
    check("init_imem_req", 64'(imem_req), 64'd0);
    fetch_en = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    repeat (8)  step(1'b1, 1'b1, 1'b0, '0);
    repeat (10) step(1'b1, 1'b0, 1'b0, '0);
    repeat (6)  step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    repeat (8)  step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 16'hFFFE);
    repeat (8)  step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 16'h0100);
    repeat (4)  step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 16'h0200);
    repeat (4)  step(1'b0, 1'b1, 1'b0, '0);
    repeat (4)  step(1'b1, 1'b0, 1'b0, '0);
    do_reset();
    repeat (6)  step(1'b1, 1'b1, 1'b0, '0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) < 8, ($urandom % 10) < 7, ($urandom % 20) == 0,
           PC_W'($urandom));
    end

    repeat (10) step(1'b0, 1'b1, 1'b0, '0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("model_empty", 64'(m_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
